// File: rtl/lab2_registerfile_param_if.sv
// Register-file port bundle: write port, two read selects, dirty/count status.
// The master drives the write and read selects; the slave returns read data and status.
interface lab2_registerfile_param_if #(
  parameter int W  = 8,
  parameter int AW = 3
);
  logic              we;
  logic [W-1:0]      in;
  logic [AW-1:0]     sel_dest;
  logic [AW-1:0]     sel1;
  logic [AW-1:0]     sel2;
  logic              clr_dirty;
  logic [W-1:0]      out1;
  logic [W-1:0]      out2;
  logic [2**AW-1:0]  dirty;
  logic [7:0]        wr_count;

  modport master (
    output we, in, sel_dest, sel1, sel2, clr_dirty,
    input  out1, out2, dirty, wr_count
  );

  modport slave (
    input  we, in, sel_dest, sel1, sel2, clr_dirty,
    output out1, out2, dirty, wr_count
  );
endinterface

// File: rtl/lab2_registerfile_param.sv
// Parametrised 2**AW x W register file: two combinational read ports, one write port,
// optional write-through bypass, optional hardwired-zero r0, dirty vector and write counter.
module lab2_registerfile_param #(
  parameter int W         = 8,
  parameter int AW        = 3,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  lab2_registerfile_param_if.slave bus
);
  localparam int N = 2**AW;

  logic [N-1:0][W-1:0] r_regs;
  logic [N-1:0]        r_dirty;
  logic [7:0]          r_wr_count;
  logic                w_acc;
  logic [N-1:0]        w_dest_oh;
  logic [N-1:0]        w_dirty_nxt;

  // Reset gates acceptance so that asserting it also kills any in-flight bypass.
  assign w_acc = reset && bus.we && !(ZERO_REG0 && (bus.sel_dest == '0));

  assign w_dest_oh   = {{(N-1){1'b0}}, 1'b1} << bus.sel_dest;
  // Write wins over a simultaneous clear for its own bit.
  assign w_dirty_nxt = (bus.clr_dirty ? '0 : r_dirty) | (w_acc ? w_dest_oh : '0);

  function automatic logic [W-1:0] rd_port(
    input logic [AW-1:0]         s,
    input logic [N-1:0][W-1:0]   regs,
    input logic                  acc,
    input logic [AW-1:0]         dst,
    input logic [W-1:0]          din
  );
    if (ZERO_REG0 && (s == '0))         return '0;
    if (BYPASS && acc && (s == dst))    return din;
    return regs[s];
  endfunction

  assign bus.out1     = rd_port(bus.sel1, r_regs, w_acc, bus.sel_dest, bus.in);
  assign bus.out2     = rd_port(bus.sel2, r_regs, w_acc, bus.sel_dest, bus.in);
  assign bus.dirty    = r_dirty;
  assign bus.wr_count = r_wr_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs     <= '0;
      r_dirty    <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_acc) r_regs[bus.sel_dest] <= bus.in;
      r_dirty <= w_dirty_nxt;
      if (w_acc && (r_wr_count != 8'hFF)) r_wr_count <= r_wr_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_lab2_registerfile_param.sv
// Scoreboard bench for three register-file configurations driven with shared stimulus:
// a = bypass, b = no bypass, c = bypass + hardwired-zero r0.
module tb_lab2_registerfile_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0, clr = 1'b0;
  logic [7:0] din = '0;
  logic [2:0] dst = '0, s1 = '0, s2 = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lab2_registerfile_param_if #(.W(8), .AW(3)) ifa ();
  lab2_registerfile_param_if #(.W(8), .AW(3)) ifb ();
  lab2_registerfile_param_if #(.W(8), .AW(3)) ifc ();

  assign ifa.we = we;  assign ifa.in = din; assign ifa.sel_dest = dst;
  assign ifa.sel1 = s1; assign ifa.sel2 = s2; assign ifa.clr_dirty = clr;
  assign ifb.we = we;  assign ifb.in = din; assign ifb.sel_dest = dst;
  assign ifb.sel1 = s1; assign ifb.sel2 = s2; assign ifb.clr_dirty = clr;
  assign ifc.we = we;  assign ifc.in = din; assign ifc.sel_dest = dst;
  assign ifc.sel1 = s1; assign ifc.sel2 = s2; assign ifc.clr_dirty = clr;

  lab2_registerfile_param #(.W(8), .AW(3), .BYPASS(1'b1), .ZERO_REG0(1'b0))
    ua (.clk(clk), .reset(rst), .bus(ifa));
  lab2_registerfile_param #(.W(8), .AW(3), .BYPASS(1'b0), .ZERO_REG0(1'b0))
    ub (.clk(clk), .reset(rst), .bus(ifb));
  lab2_registerfile_param #(.W(8), .AW(3), .BYPASS(1'b1), .ZERO_REG0(1'b1))
    uc (.clk(clk), .reset(rst), .bus(ifc));

  typedef struct {
    logic [7:0] o1;
    logic [7:0] o2;
    logic [7:0] dr;
    logic [7:0] cn;
  } exp_t;

  exp_t sb_q[$];

  // Reference state per configuration
  bit         byp [3] = '{1'b1, 1'b0, 1'b1};
  bit         z0  [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] m_reg [3][8];
  logic [7:0] m_dirty [3];
  int         m_cnt [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_acc(input int c);
    return rst && we && !(z0[c] && dst == 3'd0);
  endfunction

  function automatic logic [7:0] m_rd(input int c, input logic [2:0] s);
    if (z0[c] && s == 3'd0) return 8'h00;
    if (byp[c] && m_acc(c) && s == dst) return din;
    return m_reg[c][s];
  endfunction

  function automatic exp_t obs(input int c);
    exp_t e;
    case (c)
      0:       begin e.o1 = ifa.out1; e.o2 = ifa.out2; e.dr = ifa.dirty; e.cn = ifa.wr_count; end
      1:       begin e.o1 = ifb.out1; e.o2 = ifb.out2; e.dr = ifb.dirty; e.cn = ifb.wr_count; end
      default: begin e.o1 = ifc.out1; e.o2 = ifc.out2; e.dr = ifc.dirty; e.cn = ifc.wr_count; end
    endcase
    return e;
  endfunction

  task automatic m_clear();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 8; k++) m_reg[c][k] = 8'h00;
      m_dirty[c] = 8'h00;
      m_cnt[c]   = 0;
    end
  endtask

  // Push predictions for every configuration, then pop and compare against the DUTs.
  task automatic cmp_all(input string tag);
    exp_t e, g;
    for (int c = 0; c < 3; c++) begin
      e.o1 = m_rd(c, s1);
      e.o2 = m_rd(c, s2);
      e.dr = m_dirty[c];
      e.cn = 8'(m_cnt[c]);
      sb_q.push_back(e);
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      e = sb_q.pop_front();
      g = obs(c);
      chk($sformatf("%s_c%0d_out1", tag, c), 32'(g.o1), 32'(e.o1));
      chk($sformatf("%s_c%0d_out2", tag, c), 32'(g.o2), 32'(e.o2));
      chk($sformatf("%s_c%0d_dirty", tag, c), 32'(g.dr), 32'(e.dr));
      chk($sformatf("%s_c%0d_cnt", tag, c), 32'(g.cn), 32'(e.cn));
    end
  endtask

  task automatic set(input string tag, input logic w, input logic [7:0] d, input logic [2:0] ds,
                     input logic [2:0] a, input logic [2:0] b, input logic cl);
    we = w; din = d; dst = ds; s1 = a; s2 = b; clr = cl;
    cmp_all(tag);
  endtask

  // Advance through the rising edge, updating the model, and return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) m_clear();
    else begin
      for (int c = 0; c < 3; c++) begin
        bit acc;
        acc = m_acc(c);
        if (clr) m_dirty[c] = 8'h00;
        if (acc) begin
          m_reg[c][dst]   = din;
          m_dirty[c][dst] = 1'b1;
          if (m_cnt[c] < 255) m_cnt[c]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_clear();
    set("rst", 1'b0, 8'h00, 3'd0, 3'd0, 3'd1, 1'b0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    m_clear();
    @(negedge clk);

    // 1: basic write then read
    do_reset();
    set("t1w", 1'b1, 8'hA5, 3'd3, 3'd0, 3'd0, 1'b0); tick();
    set("t1r", 1'b0, 8'h00, 3'd0, 3'd3, 3'd0, 1'b0);
    chk("t1_out1", 32'(ifa.out1), 32'h A5);
    chk("t1_out2", 32'(ifa.out2), 32'h00);
    chk("t1_dirty", 32'(ifa.dirty), 32'h08);
    chk("t1_cnt", 32'(ifa.wr_count), 32'd1);
    tick();

    // 2: bypass vs no bypass
    set("t2w", 1'b1, 8'h3C, 3'd5, 3'd5, 3'd5, 1'b0);
    chk("t2_byp_o1", 32'(ifa.out1), 32'h3C);
    chk("t2_byp_o2", 32'(ifa.out2), 32'h3C);
    chk("t2_nob_o1", 32'(ifb.out1), 32'h00);
    chk("t2_nob_o2", 32'(ifb.out2), 32'h00);
    tick();
    set("t2r", 1'b0, 8'h00, 3'd0, 3'd5, 3'd5, 1'b0);
    chk("t2_nob_after", 32'(ifb.out1), 32'h3C);
    tick();

    // 3: hardwired zero register
    set("t3w0", 1'b1, 8'hFF, 3'd0, 3'd0, 3'd0, 1'b0);
    chk("t3_z0_byp", 32'(ifc.out1), 32'h00);
    tick();
    set("t3r0", 1'b0, 8'h00, 3'd0, 3'd0, 3'd3, 1'b0);
    chk("t3_z0_out1", 32'(ifc.out1), 32'h00);
    chk("t3_z0_dirty0", 32'(ifc.dirty[0]), 32'd0);
    chk("t3_z0_cnt", 32'(ifc.wr_count), 32'd2);
    chk("t3_a_r0", 32'(ifa.out1), 32'hFF);
    tick();
    do_reset();
    set("t3w1", 1'b1, 8'h11, 3'd1, 3'd1, 3'd0, 1'b0); tick();
    set("t3r1", 1'b0, 8'h00, 3'd0, 3'd1, 3'd0, 1'b0);
    chk("t3_z0_dirty", 32'(ifc.dirty), 32'h02);
    tick();

    // 4: clear dirty concurrent with a write
    do_reset();
    set("t4w1", 1'b1, 8'h21, 3'd1, 3'd0, 3'd0, 1'b0); tick();
    set("t4w2", 1'b1, 8'h22, 3'd2, 3'd0, 3'd0, 1'b0); tick();
    set("t4w4", 1'b1, 8'h24, 3'd4, 3'd0, 3'd0, 1'b0); tick();
    set("t4cw", 1'b1, 8'h66, 3'd6, 3'd1, 3'd2, 1'b1); tick();
    set("t4r12", 1'b0, 8'h00, 3'd0, 3'd1, 3'd2, 1'b0);
    chk("t4_dirty", 32'(ifa.dirty), 32'h40);
    chk("t4_r1", 32'(ifa.out1), 32'h21);
    chk("t4_r2", 32'(ifa.out2), 32'h22);
    chk("t4_cnt", 32'(ifa.wr_count), 32'd4);
    tick();
    set("t4r46", 1'b0, 8'h00, 3'd0, 3'd4, 3'd6, 1'b0);
    chk("t4_r4", 32'(ifa.out1), 32'h24);
    chk("t4_r6", 32'(ifa.out2), 32'h66);
    tick();

    // 5: wr_count saturation
    do_reset();
    for (int i = 0; i < 260; i++) begin
      set("t5w", 1'b1, 8'($urandom_range(0, 255)), 3'($urandom_range(1, 7)),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick();
    end
    set("t5r", 1'b0, 8'h00, 3'd0, 3'd1, 3'd2, 1'b0);
    chk("t5_cnt_a", 32'(ifa.wr_count), 32'd255);
    chk("t5_cnt_c", 32'(ifc.wr_count), 32'd255);
    tick();

    // 6: async reset mid-cycle discards the in-flight write
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set("t6f", 1'b1, 8'(8'h10 + i), 3'(i), 3'(i), 3'(7 - i), 1'b0);
      tick();
    end
    set("t6pre", 1'b1, 8'h99, 3'd3, 3'd3, 3'd5, 1'b0);
    #2;
    rst = 1'b0;
    m_clear();
    cmp_all("t6rst");
    chk("t6_out1", 32'(ifa.out1), 32'h00);
    chk("t6_out2", 32'(ifa.out2), 32'h00);
    chk("t6_dirty", 32'(ifa.dirty), 32'h00);
    chk("t6_cnt", 32'(ifa.wr_count), 32'd0);
    tick();
    we = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set("t6rd", 1'b0, 8'h00, 3'd0, 3'(i), 3'(7 - i), 1'b0);
      chk($sformatf("t6_rd%0d", i), 32'(ifb.out1), 32'h00);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
